// File: rtl/ranging_pkg.sv
// ranging_pkg: shared types and constants for the ultrasonic ranging scheduler.
//   state_t       - scheduler FSM states
//   TIMEOUT_CODE  - dist_data value reported when no echo completes in time
//   CM_MAX        - saturation ceiling of the cm counter (one below TIMEOUT_CODE)
//   DEF_*         - default timing constants for a 50 MHz clock
package ranging_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        REPORT,
        GAP
    } state_t;

    localparam logic [15:0] TIMEOUT_CODE = 16'hFFFF;
    localparam logic [15:0] CM_MAX       = 16'hFFFE;

    localparam int unsigned DEF_N_SENS      = 4;
    localparam int unsigned DEF_TRIG_CYC    = 500;      // 10 us
    localparam int unsigned DEF_CM_CYC      = 2900;     // 58 us per cm
    localparam int unsigned DEF_TIMEOUT_CYC = 1900000;  // 38 ms
    localparam int unsigned DEF_GAP_CYC     = 3000000;  // 60 ms

endpackage

// File: rtl/echo_timer.sv
// echo_timer: per-slot timing engine shared by all sensors.
//   clk     - clock
//   rst_n   - asynchronous active-low reset
//   clear   - synchronous clear of all counters (has priority)
//   run     - elapsed-time counter enable (waiting or measuring)
//   measure - echo measurement active
//   echo    - synchronized echo of the selected sensor
//   cm      - distance in cm, saturating at CM_MAX
//   expired - high in the TIMEOUT_CYC-th clock since the last clear while run is high
module echo_timer
    import ranging_pkg::*;
#(
    parameter int unsigned CM_CYC      = DEF_CM_CYC,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        run,
    input  logic        measure,
    input  logic        echo,
    output logic [15:0] cm,
    output logic        expired
);

    localparam int unsigned PW = (CM_CYC > 1) ? $clog2(CM_CYC) : 1;
    localparam int unsigned EW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [PW-1:0] pre_q, pre_d;
    logic [15:0]   cm_q, cm_d;
    logic [EW-1:0] elapsed_q, elapsed_d;
    logic          wrap;

    assign expired = run && (elapsed_q == EW'(TIMEOUT_CYC - 1));
    assign wrap    = (pre_q == PW'(CM_CYC - 1));
    assign cm      = cm_q;

    always_comb begin
        pre_d     = pre_q;
        cm_d      = cm_q;
        elapsed_d = elapsed_q;
        if (clear) begin
            pre_d     = '0;
            cm_d      = '0;
            elapsed_d = '0;
        end else begin
            if (run && !expired) begin
                elapsed_d = elapsed_q + EW'(1);
            end
            if (measure && echo) begin
                if (wrap) begin
                    pre_d = '0;
                    // Stop one short of the timeout code so a real reading never aliases it.
                    if (cm_q != CM_MAX) begin
                        cm_d = cm_q + 16'd1;
                    end
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q     <= '0;
            cm_q      <= '0;
            elapsed_q <= '0;
        end else begin
            pre_q     <= pre_d;
            cm_q      <= cm_d;
            elapsed_q <= elapsed_d;
        end
    end

endmodule

// File: rtl/ranging_scheduler.sv
// ranging_scheduler: round-robin trigger/echo sequencer for N_SENS ultrasonic sensors.
//   CLK_50M    - clock
//   RST        - asynchronous active-low reset
//   En         - run enable; a slot in progress always completes
//   Echo       - raw asynchronous echo lines
//   Trig       - registered trigger lines, one-hot or zero
//   dist_data  - distance in cm, TIMEOUT_CODE on timeout; held until next report
//   dist_idx   - sensor index of dist_data; held until next report
//   dist_valid - one-cycle strobe for dist_data/dist_idx
//   busy       - high whenever the FSM is not IDLE
module ranging_scheduler
    import ranging_pkg::*;
#(
    parameter int unsigned N_SENS      = DEF_N_SENS,
    parameter int unsigned TRIG_CYC    = DEF_TRIG_CYC,
    parameter int unsigned CM_CYC      = DEF_CM_CYC,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int unsigned GAP_CYC     = DEF_GAP_CYC,
    localparam int unsigned IDX_W      = (N_SENS > 1) ? $clog2(N_SENS) : 1
) (
    input  logic              CLK_50M,
    input  logic              RST,
    input  logic              En,
    input  logic [N_SENS-1:0] Echo,
    output logic [N_SENS-1:0] Trig,
    output logic [15:0]       dist_data,
    output logic [IDX_W-1:0]  dist_idx,
    output logic              dist_valid,
    output logic              busy
);

    logic [N_SENS-1:0] echo_meta, echo_sync;
    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [31:0]       cyc_q, cyc_d;
    logic [15:0]       data_q, data_d;
    logic [IDX_W-1:0]  didx_q, didx_d;
    logic              valid_q;
    logic [N_SENS-1:0] trig_q, trig_d;
    logic              sel_echo;
    logic              report, rep_timeout;
    logic              tmr_clear, tmr_run, tmr_meas, tmr_expired;
    logic [15:0]       tmr_cm;

    // Two-flop synchronizer on every echo line.
    always_ff @(posedge CLK_50M or negedge RST) begin
        if (!RST) begin
            echo_meta <= '0;
            echo_sync <= '0;
        end else begin
            echo_meta <= Echo;
            echo_sync <= echo_meta;
        end
    end

    assign sel_echo = echo_sync[idx_q];
    assign tmr_run  = (state_q == WAIT_RISE) || (state_q == MEASURE);
    assign tmr_meas = (state_q == MEASURE);

    echo_timer #(
        .CM_CYC      (CM_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_echo_timer (
        .clk     (CLK_50M),
        .rst_n   (RST),
        .clear   (tmr_clear),
        .run     (tmr_run),
        .measure (tmr_meas),
        .echo    (sel_echo),
        .cm      (tmr_cm),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cyc_d       = cyc_q;
        data_d      = data_q;
        didx_d      = didx_q;
        tmr_clear   = 1'b0;
        report      = 1'b0;
        rep_timeout = 1'b0;
        trig_d      = '0;

        unique case (state_q)
            IDLE: begin
                if (En) begin
                    state_d = TRIG;
                    cyc_d   = '0;
                end
            end
            TRIG: begin
                if (cyc_q == 32'(TRIG_CYC - 1)) begin
                    state_d   = WAIT_RISE;
                    cyc_d     = '0;
                    tmr_clear = 1'b1;
                end else begin
                    cyc_d = cyc_q + 32'd1;
                end
            end
            WAIT_RISE: begin
                // Clearing again on the rise restarts the timeout window for the echo itself.
                if (sel_echo) begin
                    state_d   = MEASURE;
                    tmr_clear = 1'b1;
                end else if (tmr_expired) begin
                    report      = 1'b1;
                    rep_timeout = 1'b1;
                end
            end
            MEASURE: begin
                // A falling edge wins over a simultaneous timeout.
                if (!sel_echo) begin
                    report = 1'b1;
                end else if (tmr_expired) begin
                    report      = 1'b1;
                    rep_timeout = 1'b1;
                end
            end
            REPORT: begin
                state_d = GAP;
                cyc_d   = '0;
            end
            GAP: begin
                if (cyc_q == 32'(GAP_CYC - 1)) begin
                    cyc_d   = '0;
                    idx_d   = (idx_q == IDX_W'(N_SENS - 1)) ? '0 : idx_q + IDX_W'(1);
                    state_d = En ? TRIG : IDLE;
                end else begin
                    cyc_d = cyc_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Result is captured on entry to REPORT so it is stable during the strobe.
        if (report) begin
            state_d = REPORT;
            didx_d  = idx_q;
            data_d  = rep_timeout ? TIMEOUT_CODE : tmr_cm;
        end

        if (state_d == TRIG) begin
            trig_d[idx_d] = 1'b1;
        end
    end

    always_ff @(posedge CLK_50M or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cyc_q   <= '0;
            data_q  <= '0;
            didx_q  <= '0;
            valid_q <= 1'b0;
            trig_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cyc_q   <= cyc_d;
            data_q  <= data_d;
            didx_q  <= didx_d;
            valid_q <= report;
            trig_q  <= trig_d;
        end
    end

    assign Trig       = trig_q;
    assign dist_data  = data_q;
    assign dist_idx   = didx_q;
    assign dist_valid = valid_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ranging_scheduler.sv
// tb_ranging_scheduler: directed self-checking bench for ranging_scheduler.
module tb_ranging_scheduler;

    localparam int N_SENS      = 4;
    localparam int TRIG_CYC    = 5;
    localparam int CM_CYC      = 10;
    localparam int TIMEOUT_CYC = 400;
    localparam int GAP_CYC     = 20;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  echo;
    logic [3:0]  trig;
    logic [15:0] dist_data;
    logic [1:0]  dist_idx;
    logic        dist_valid;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int valid_cnt = 0;
    int rep_idx_q[$];
    int rep_data_q[$];

    ranging_scheduler #(
        .N_SENS      (N_SENS),
        .TRIG_CYC    (TRIG_CYC),
        .CM_CYC      (CM_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .GAP_CYC     (GAP_CYC)
    ) dut (
        .CLK_50M    (clk),
        .RST        (rst),
        .En         (en),
        .Echo       (echo),
        .Trig       (trig),
        .dist_data  (dist_data),
        .dist_idx   (dist_idx),
        .dist_valid (dist_valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Report logger.
    always @(negedge clk) begin
        if (dist_valid) begin
            rep_idx_q.push_back(int'(dist_idx));
            rep_data_q.push_back(int'(dist_data));
            valid_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // en_mode: 0 keep En, 1 drop En at trigger start, 2 drop En mid-echo.
    // echo_sens < 0: no echo, noise on Echo, and the wait length is checked.
    task automatic run_slot(input string tag, input int exp_idx, input int echo_sens,
                            input int echo_len, input int en_mode, input logic [3:0] noise,
                            input int exp_data);
        int n;
        int w;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (trig == 4'b0 && n < 2000);
        check({tag, "_trig_sel"}, 32'(trig), 32'(1) << exp_idx);
        if (en_mode == 1) en = 1'b0;
        w = 0;
        while (trig != 4'b0 && w < 100) begin
            w++;
            @(negedge clk);
        end
        check({tag, "_trig_width"}, w, TRIG_CYC);
        if (echo_sens >= 0) begin
            echo[echo_sens] = 1'b1;
            for (int i = 0; i < echo_len; i++) begin
                @(negedge clk);
                if (en_mode == 2 && i == echo_len / 2) en = 1'b0;
            end
            echo[echo_sens] = 1'b0;
        end else begin
            echo = noise;
            n = 0;
            while (!dist_valid && n < 1000) begin
                n++;
                @(negedge clk);
            end
            check({tag, "_wait_cycles"}, n, TIMEOUT_CYC);
            echo = 4'b0;
        end
        n = 0;
        while (rep_idx_q.size() == 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        if (rep_idx_q.size() == 0) begin
            check({tag, "_report_seen"}, 0, 1);
        end else begin
            check({tag, "_idx"}, rep_idx_q.pop_front(), exp_idx);
            check({tag, "_data"}, rep_data_q.pop_front(), exp_data);
        end
        @(negedge clk);
    endtask

    initial begin
        int v0;
        int n;
        rst  = 1'b0;
        en   = 1'b0;
        echo = 4'b0;
        repeat (3) @(negedge clk);
        check("rst_trig", 32'(trig), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(dist_valid), 0);
        check("rst_data", 32'(dist_data), 0);
        check("rst_idx", 32'(dist_idx), 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Sensor 0, 123-clock echo -> 12 cm; En dropped at trigger, then IDLE.
        @(negedge clk);
        en = 1'b1;
        run_slot("s0_123", 0, 0, 123, 1, 4'b0, 12);
        repeat (GAP_CYC + 5) @(negedge clk);
        check("s0_idle_busy", 32'(busy), 0);

        // Sensor 1 short echo, then sensor 2 never rises with noise on other lines.
        en = 1'b1;
        run_slot("s1_35", 1, 1, 35, 0, 4'b0, 3);
        run_slot("s2_norise", 2, -1, 0, 1, 4'b1011, 32'hFFFF);
        repeat (GAP_CYC + 5) @(negedge clk);
        check("s2_idle_busy", 32'(busy), 0);

        // Sensor 3 echo stuck high 500 clocks -> timeout, then back to IDLE.
        en = 1'b1;
        run_slot("s3_stuck", 3, 3, 500, 1, 4'b0, 32'hFFFF);
        check("s3_idle_busy", 32'(busy), 0);

        // Five back-to-back slots; first one shows idx wrapped to 0.
        en = 1'b1;
        v0 = valid_cnt;
        run_slot("rr0", 0, 0, 25, 0, 4'b0, 2);
        run_slot("rr1", 1, 1, 45, 0, 4'b0, 4);
        run_slot("rr2", 2, 2, 65, 0, 4'b0, 6);
        run_slot("rr3", 3, 3, 15, 0, 4'b0, 1);
        run_slot("rr4", 0, 0, 55, 1, 4'b0, 5);
        check("rr_valid_count", valid_cnt - v0, 5);
        check("rr_valid_pulse", 32'(dist_valid), 0);
        check("rr_hold_data", 32'(dist_data), 5);
        repeat (GAP_CYC + 5) @(negedge clk);
        check("rr_idle_busy", 32'(busy), 0);
        check("rr_hold_idle_data", 32'(dist_data), 5);
        check("rr_hold_idle_idx", 32'(dist_idx), 0);

        // En dropped during MEASURE: slot still reports, then IDLE.
        en = 1'b1;
        run_slot("en_mid", 1, 1, 75, 2, 4'b0, 7);
        repeat (GAP_CYC + 5) @(negedge clk);
        check("en_mid_busy", 32'(busy), 0);
        check("en_mid_trig", 32'(trig), 0);

        // Reset during TRIG of sensor 1.
        en = 1'b1;
        run_slot("pre2", 2, 2, 15, 0, 4'b0, 1);
        run_slot("pre3", 3, 3, 15, 0, 4'b0, 1);
        run_slot("pre0", 0, 0, 15, 0, 4'b0, 1);
        n = 0;
        while (trig == 4'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_trig_sel", 32'(trig), 32'b0010);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_trig", 32'(trig), 0);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_data", 32'(dist_data), 0);
        check("rst_mid_valid", 32'(dist_valid), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (trig == 4'b0 && n < 200);
        check("rst_restart_idx", 32'(trig), 32'b0001);
        en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ranging_scheduler.md
RANGING_SCHEDULER -- requirements
Module: ranging_scheduler

Interface
REQ-001 The block SHALL have parameter N_SENS, default 4: number of ultrasonic sensors sequenced.
REQ-002 The block SHALL have parameter TRIG_CYC, default 500: trigger pulse width in clocks (10 us at 50 MHz).
REQ-003 The block SHALL have parameter CM_CYC, default 2900: echo clocks per centimetre (58 us at 50 MHz).
REQ-004 The block SHALL have parameter TIMEOUT_CYC, default 1900000: maximum wait or echo time per sensor, 38 ms.
REQ-005 The block SHALL have parameter GAP_CYC, default 3000000: idle clocks after each sensor slot, 60 ms.
REQ-006 Port CLK_50M  input  1: the single clock for the whole block.
REQ-007 Port RST  input  1: asynchronous, active-low reset.
REQ-008 Port En  input  1: while high, scheduling runs; while low, the block finishes its current slot and then parks in IDLE.
REQ-009 Port Echo  input  N_SENS: raw, asynchronous echo lines, one per sensor.
REQ-010 Port Trig  output  N_SENS: trigger lines, one-hot or zero.
REQ-011 Port dist_data  output  16: distance result in cm; 16'hFFFF means timeout.
REQ-012 Port dist_idx  output  clog2(N_SENS): index of the sensor that dist_data belongs to.
REQ-013 Port dist_valid  output  1: one-cycle strobe qualifying dist_data and dist_idx.
REQ-014 Port busy  output  1: high in every state except IDLE.

Function
REQ-015 Each Echo bit SHALL pass through a 2-FF synchronizer; all logic SHALL use only the synchronized values.
REQ-016 The FSM states SHALL be IDLE, TRIG, WAIT_RISE, MEASURE, REPORT and GAP.
REQ-017 IDLE SHALL move to TRIG on the first cycle that En=1, with slot index = 0 after reset or the next index otherwise.
REQ-018 TRIG SHALL drive Trig[idx]=1 for exactly TRIG_CYC clocks, then move to WAIT_RISE.
REQ-019 WAIT_RISE SHALL move to MEASURE when the synchronized Echo[idx] is 1.
REQ-020 WAIT_RISE SHALL move to REPORT with timeout if TIMEOUT_CYC clocks elapse first.
REQ-021 MEASURE SHALL count clocks with a prescaler that wraps at CM_CYC-1 and increments the cm counter on each wrap.
REQ-022 MEASURE SHALL move to REPORT on the falling edge of Echo[idx], or with timeout at TIMEOUT_CYC clocks.
REQ-023 The cm counter SHALL saturate at 16'hFFFE, so a real measurement never reads as the timeout code.
REQ-024 REPORT SHALL last one cycle: dist_valid=1, dist_idx=idx, and dist_data=cm count, or 16'hFFFF on timeout.
REQ-025 dist_data and dist_idx SHALL hold their value until the next REPORT.
REQ-026 REPORT SHALL move to GAP.
REQ-027 GAP SHALL wait GAP_CYC clocks, then advance idx with wrap N_SENS-1 -> 0.
REQ-028 At the end of GAP, the FSM SHALL go to TRIG if En=1, else to IDLE.
REQ-029 Echo already high on entry to WAIT_RISE SHALL count as an immediate rise.
REQ-030 Echo activity on non-selected sensors SHALL be ignored.
REQ-031 Echo falling in the same cycle the timeout count is reached SHALL report the measured value, not the timeout code.
REQ-032 En deasserted mid-slot SHALL NOT truncate the slot.

Reset
REQ-033 RST low SHALL asynchronously force: state IDLE, idx 0, Trig=0, dist_data=0, dist_idx=0, dist_valid=0, busy=0, all counters and synchronizers 0.
REQ-034 Reset asserted mid-TRIG SHALL drop Trig within the reset assertion, with no glitch to another sensor.

Structure
REQ-035 Package ranging_pkg SHALL hold the state enum, the timeout code 16'hFFFF and the default timing constants.
REQ-036 One sub-module, echo_timer, SHALL hold the prescaler, cm counter, saturation and timeout compare.
REQ-037 echo_timer SHALL be instantiated once and shared across slots; it is cleared on entry to WAIT_RISE.

Verification (bench overrides TRIG_CYC=5, CM_CYC=10, TIMEOUT_CYC=400, GAP_CYC=20)
REQ-038 Directed test: sensor 0 echo high for 123 clocks -> dist_valid with idx 0 and dist_data=12; Trig[0] high exactly 5 clocks.
REQ-039 Directed test: sensor 2 never rises -> after 400 clocks in WAIT_RISE, dist_data=16'hFFFF and idx=2.
REQ-040 Directed test: echo held high 500 clocks -> timeout report of 16'hFFFF, then GAP, then idx advances.
REQ-041 Directed test: En held high through 5 slots -> idx sequence 0,1,2,3,0 with exactly one dist_valid per slot.
REQ-042 Directed test: En dropped during MEASURE -> the current slot still reports, then the FSM enters IDLE and busy=0.
REQ-043 Directed test: RST pulsed low during TRIG of sensor 1 -> Trig=0 immediately; after release the next slot starts at idx 0.
